// File: rtl/result_display.sv
// rtl/result_display.sv - 8-digit multiplexed 7-segment display of controller result and phase
module result_display #(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [4:0]  phase,
  input  logic        mode,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        busy
);

  localparam int              CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [6:0]      G_MINUS   = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             lat_mode_q, lat_mode_d;
  logic [15:0]      lat_value_q, lat_value_d;
  logic             sign_q, sign_d;
  logic [15:0]      mag_q, mag_d;
  logic [19:0]      bcd_q, bcd_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             valid_q, valid_d;
  logic [16:0]      cmt_q, cmt_d;
  logic [6:0][6:0]  disp_q, disp_d;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             busy_q, busy_d;

  logic             start;
  logic [2:0]       nd;
  logic [6:0][6:0]  frame;
  logic [6:0]       phase_g;
  logic [7:0][6:0]  shown;

  // Frame assembled from the finished conversion; only latched into disp_q in DONE.
  always_comb begin
    frame = '0;
    nd    = 3'd1;
    if (!lat_mode_q) begin
      for (int i = 0; i < 4; i++) frame[i] = glyph(lat_value_q[4*i +: 4]);
    end else begin
      for (int i = 1; i < 5; i++)
        if (bcd_q[4*i +: 4] != 4'd0) nd = 3'(i + 1);
      for (int i = 0; i < 5; i++)
        if (3'(i) < nd) frame[i] = glyph(bcd_q[4*i +: 4]);
      if (sign_q) frame[nd] = G_MINUS;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_mode_d  = lat_mode_q;
    lat_value_d = lat_value_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    valid_d     = valid_q;
    cmt_d       = cmt_q;
    disp_d      = disp_q;
    start       = !valid_q || ({mode, value} != cmt_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          lat_mode_d  = mode;
          lat_value_d = value;
        end
      end
      S_LOAD: begin
        sign_d    = lat_value_q[15];
        mag_d     = lat_value_q[15] ? (~lat_value_q + 16'd1) : lat_value_q;
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = lat_mode_q ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        {bcd_d, mag_d} = {add3(bcd_q), mag_q} << 1;
        bit_cnt_d      = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = frame;
        valid_d = 1'b1;
        cmt_d   = {lat_mode_q, lat_value_q};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Phase bypasses the converter so digit 7 tracks the controller live.
  always_comb begin
    case (phase)
      5'b00001: phase_g = glyph(4'd1);
      5'b00010: phase_g = glyph(4'd2);
      5'b00100: phase_g = glyph(4'd3);
      5'b01000: phase_g = glyph(4'd4);
      5'b10000: phase_g = glyph(4'd5);
      default:  phase_g = 7'b0000000;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    shown = {phase_g, disp_q};
    seg_d = ACTIVE_LOW ? ~shown[idx_q] : shown[idx_q];
    an_d  = ACTIVE_LOW ? ~(8'd1 << idx_q) : (8'd1 << idx_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_mode_q  <= 1'b0;
      lat_value_q <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      valid_q     <= 1'b0;
      cmt_q       <= '0;
      disp_q      <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      seg_q       <= ACTIVE_LOW ? 7'h7F : 7'h00;
      an_q        <= ACTIVE_LOW ? 8'hFF : 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_mode_q  <= lat_mode_d;
      lat_value_q <= lat_value_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      valid_q     <= valid_d;
      cmt_q       <= cmt_d;
      disp_q      <= disp_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      busy_q      <= busy_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - randomized and directed bench for result_display
module tb_result_display;

  localparam int SD = 4;
  typedef logic [7:0][6:0] frame_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h1234;
  logic [4:0]  phase = 5'b00100;
  logic        mode  = 1'b0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        busy;

  int     tests = 0;
  int     fails = 0;
  int     k = 0;
  frame_t exp_f;

  result_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .value(value), .phase(phase), .mode(mode),
    .seg(seg), .an(an), .busy(busy)
  );

  always #5 clock = ~clock;

  // Non-reset edges since the last reset edge; scan position follows from it.
  always @(posedge clock) k <= reset ? 0 : k + 1;

  function automatic logic [6:0] gl(input int d);
    case (d)
      0: return 7'b0111111;   1: return 7'b0000110;   2: return 7'b1011011;
      3: return 7'b1001111;   4: return 7'b1100110;   5: return 7'b1101101;
      6: return 7'b1111101;   7: return 7'b0000111;   8: return 7'b1111111;
      9: return 7'b1101111;  10: return 7'b1110111;  11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110;  14: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  function automatic frame_t model(input logic m, input logic [15:0] v, input logic [4:0] ph);
    frame_t f;
    int mag, nd, t;
    f = '0;
    if (!m) begin
      for (int i = 0; i < 4; i++) f[i] = gl(int'(v[4*i +: 4]));
    end else begin
      mag = v[15] ? 65536 - int'(v) : int'(v);
      nd = 1;
      for (t = mag / 10; t > 0; t = t / 10) nd++;
      t = mag;
      for (int i = 0; i < nd; i++) begin
        f[i] = gl(t % 10);
        t = t / 10;
      end
      if (v[15]) f[nd] = 7'b1000000;
    end
    if ($countones(ph) == 1)
      for (int i = 0; i < 5; i++) if (ph[i]) f[7] = gl(i + 1);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_scan(input string tag);
    int idx;
    repeat (8 * SD) begin
      @(negedge clock);
      idx = ((k - 1) / SD) % 8;
      chk($sformatf("%s_an_d%0d", tag, idx), {24'd0, an}, {24'd0, ~(8'd1 << idx)});
      chk($sformatf("%s_seg_d%0d", tag, idx), {25'd0, seg}, {25'd0, ~exp_f[idx]});
    end
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (busy === 1'b1) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic apply(input logic m, input logic [15:0] v, input logic [4:0] ph);
    @(negedge clock);
    mode = m; value = v; phase = ph;
    @(negedge clock);
    for (int i = 0; i < 40 && busy === 1'b1; i++) @(negedge clock);
    chk("settle", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    exp_f = model(m, v, ph);
  endtask

  initial begin
    int n, nb, r1, gap, r2, p, idx;
    logic changed, ok;
    logic b [0:59];
    frame_t f0, f16, f32;

    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);

    reset = 1'b0;
    measure_busy(n);
    chk("hex_latency", n, 2);
    repeat (2) @(negedge clock);
    exp_f = model(1'b0, 16'h1234, 5'b00100);
    check_scan("hex1234");

    @(negedge clock);
    mode = 1'b1; value = 16'hFFFB;
    measure_busy(n);
    chk("dec_latency", n, 18);
    repeat (2) @(negedge clock);
    exp_f = model(1'b1, 16'hFFFB, 5'b00100);
    check_scan("m5");

    apply(1'b1, 16'h8000, 5'b00100);
    check_scan("m32768");
    apply(1'b1, 16'h0000, 5'b00100);
    check_scan("zero");

    f0  = model(1'b1, 16'h0000, 5'b00100);
    f16 = model(1'b1, 16'h0010, 5'b00100);
    f32 = model(1'b1, 16'h0020, 5'b00100);
    @(negedge clock);
    value = 16'h0010;
    nb = 0; changed = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      b[i] = busy;
      idx = ((k - 1) / SD) % 8;
      ok = (seg === ~f0[idx]) || (seg === ~f16[idx]) || (seg === ~f32[idx]);
      chk($sformatf("no_intermediate_%0d", i), {31'd0, ok}, 32'd1);
      if (busy === 1'b1) nb++;
      if (nb == 6 && !changed) begin
        value = 16'h0020;
        changed = 1'b1;
      end
    end
    p = 0; r1 = 0; gap = 0; r2 = 0;
    while (p < 60 && b[p] !== 1'b1) p++;
    while (p < 60 && b[p] === 1'b1) begin r1++; p++; end
    while (p < 60 && b[p] !== 1'b1) begin gap++; p++; if (gap > 5) break; end
    while (p < 60 && b[p] === 1'b1) begin r2++; p++; end
    chk("midshift_run1", r1, 18);
    chk("midshift_gap", gap, 1);
    chk("midshift_run2", r2, 18);
    exp_f = f32;
    check_scan("m32");

    @(negedge clock);
    value = 16'h1234;
    repeat (5) @(negedge clock);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_an", {24'd0, an}, 32'hFF);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    reset = 1'b0;
    measure_busy(n);
    chk("post_reset_latency", n, 18);
    repeat (2) @(negedge clock);
    exp_f = model(1'b1, 16'h1234, 5'b00100);
    check_scan("m4660");

    apply(1'b1, 16'h1234, 5'b00000);
    check_scan("ph00000");
    apply(1'b1, 16'h1234, 5'b00011);
    check_scan("ph00011");
    apply(1'b1, 16'h1234, 5'b10000);
    check_scan("ph10000");

    apply(1'b0, 16'h00FF, 5'b10000);
    check_scan("hex00FF");
    apply(1'b1, 16'h00FF, 5'b10000);
    check_scan("dec255");
    apply(1'b0, 16'h00FF, 5'b10000);
    check_scan("hex00FF_again");

    for (int it = 0; it < 6; it++) begin
      logic        rm;
      logic [15:0] rv;
      logic [4:0]  rp;
      rm = 1'($urandom % 2);
      rv = 16'($urandom);
      rp = ($urandom % 2 == 0) ? 5'(1 << ($urandom % 5)) : 5'($urandom);
      apply(rm, rv, rp);
      check_scan($sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
